// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and defaults for the transmit/receive shift registers
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_tx_estado_t;
  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_MODE = 0;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/registro_de_corrimiento_transmisor_if.sv
// registro_de_corrimiento_transmisor_if: word handshake, SCLK strobes and SPI pins of the transmitter
interface registro_de_corrimiento_transmisor_if #(parameter int DATA_W = spi_pkg::SPI_DATA_W_DEF);
  logic [DATA_W-1:0] dato_i;
  logic valido_i;
  logic listo_o;
  logic psclk_i;
  logic nsclk_i;
  logic sclk_en_o;
  logic mosi_o;
  logic cs_n_o;
  logic ocupado_o;
  logic fin_o;
  modport master (
    output dato_i, valido_i, psclk_i, nsclk_i,
    input  listo_o, sclk_en_o, mosi_o, cs_n_o, ocupado_o, fin_o
  );
  modport slave (
    input  dato_i, valido_i, psclk_i, nsclk_i,
    output listo_o, sclk_en_o, mosi_o, cs_n_o, ocupado_o, fin_o
  );
endinterface

// File: rtl/registro_de_corrimiento_transmisor_contador_espera.sv
// registro_de_corrimiento_transmisor_contador_espera: loadable count-down wait counter, fin while zero
module registro_de_corrimiento_transmisor_contador_espera #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cargar,
  input  logic         contar,
  input  logic [W-1:0] valor,
  output logic         fin
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (cargar) cnt <= valor;
    else if (contar && cnt != '0) cnt <= cnt - 1'b1;
  assign fin = cnt == '0;
endmodule

// File: rtl/registro_de_corrimiento_transmisor.sv
// registro_de_corrimiento_transmisor: SPI mode-0 master transmit shift register, MSB first
module registro_de_corrimiento_transmisor
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W_DEF,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input logic clck_i,
  input logic rst_i,
  registro_de_corrimiento_transmisor_if.slave bus
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = $clog2(max_int(SETUP_CYC, HOLD_CYC) + 1);
  spi_tx_estado_t estado, estado_sig;
  logic [DATA_W-1:0] sreg, sreg_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic listo_d, ocupado_d, sclk_en_d, mosi_d, cs_n_d, fin_d;
  logic cargar, contar, espera_fin;
  logic [CW-1:0] valor;
  logic hs, ultimo;
  assign hs = bus.valido_i && bus.listo_o;
  assign ultimo = bus.psclk_i && bit_cnt == BW'(DATA_W - 1);
  assign contar = estado == SETUP || estado == HOLD;
  registro_de_corrimiento_transmisor_contador_espera #(.W(CW)) u_espera (
    .clk(clck_i), .rst(rst_i), .cargar(cargar), .contar(contar), .valor(valor), .fin(espera_fin)
  );
  always_ff @(posedge clck_i)
    if (rst_i) begin
      estado        <= IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      bus.listo_o   <= 1'b0;
      bus.ocupado_o <= 1'b0;
      bus.sclk_en_o <= 1'b0;
      bus.mosi_o    <= 1'b0;
      bus.cs_n_o    <= 1'b1;
      bus.fin_o     <= 1'b0;
    end else begin
      estado        <= estado_sig;
      sreg          <= sreg_d;
      bit_cnt       <= bit_cnt_d;
      bus.listo_o   <= listo_d;
      bus.ocupado_o <= ocupado_d;
      bus.sclk_en_o <= sclk_en_d;
      bus.mosi_o    <= mosi_d;
      bus.cs_n_o    <= cs_n_d;
      bus.fin_o     <= fin_d;
    end
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    estado_sig = hs ? SETUP : IDLE;
      SETUP:   estado_sig = espera_fin ? SHIFT : SETUP;
      SHIFT:   estado_sig = ultimo ? HOLD : SHIFT;
      HOLD:    estado_sig = espera_fin ? IDLE : HOLD;
      default: estado_sig = IDLE;
    endcase
  end
  // a simultaneous psclk/nsclk pair counts the rising edge and drops the shift
  always_comb begin
    sreg_d    = sreg;
    bit_cnt_d = bit_cnt;
    sclk_en_d = bus.sclk_en_o;
    mosi_d    = bus.mosi_o;
    cs_n_d    = bus.cs_n_o;
    fin_d     = 1'b0;
    cargar    = 1'b0;
    valor     = '0;
    listo_d   = estado_sig == IDLE;
    ocupado_d = estado_sig != IDLE;
    case (estado)
      IDLE:
        if (hs) begin
          sreg_d    = bus.dato_i;
          mosi_d    = bus.dato_i[DATA_W-1];
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          cargar    = 1'b1;
          valor     = CW'(SETUP_CYC - 1);
        end
      SETUP: sclk_en_d = espera_fin ? 1'b1 : bus.sclk_en_o;
      SHIFT:
        if (bus.psclk_i) begin
          bit_cnt_d = bit_cnt + 1'b1;
          if (ultimo) begin
            sclk_en_d = 1'b0;
            cargar    = 1'b1;
            valor     = CW'(HOLD_CYC - 1);
          end
        end else if (bus.nsclk_i && bit_cnt < BW'(DATA_W)) begin
          sreg_d = sreg << 1;
          mosi_d = sreg[DATA_W-2];
        end
      HOLD:
        if (espera_fin) begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
          fin_d  = 1'b1;
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_registro_de_corrimiento_transmisor.sv
// tb_registro_de_corrimiento_transmisor: directed checks of the SPI transmit shift register (8 and 16 bit)
module tb_registro_de_corrimiento_transmisor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  registro_de_corrimiento_transmisor_if #(.DATA_W(8))  b8 ();
  registro_de_corrimiento_transmisor_if #(.DATA_W(16)) b16 ();
  registro_de_corrimiento_transmisor #(.DATA_W(8), .SETUP_CYC(2), .HOLD_CYC(2)) u8 (
    .clck_i(clk), .rst_i(rst), .bus(b8.slave)
  );
  registro_de_corrimiento_transmisor #(.DATA_W(16), .SETUP_CYC(2), .HOLD_CYC(2)) u16 (
    .clck_i(clk), .rst_i(rst), .bus(b16.slave)
  );
  int n_assert = 0, n_fail = 0;
  int f8 = 0, f16 = 0, np8 = 0, np16 = 0, nfin8 = 0, nfin16 = 0;
  int bad_listo = 0, hi_run = 0, last_gap = 0;
  bit gap_on = 1'b0, xp8 = 1'b0, xn8 = 1'b0;
  logic [31:0] rx8 = '0, rx16 = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: SCLK model (psclk at phase 0, nsclk at phase 2 while sclk_en_o), capture, bookkeeping
  task automatic ciclo();
    bit e8, e16;
    e8  = b8.sclk_en_o;
    e16 = b16.sclk_en_o;
    b8.psclk_i  = (e8 && f8 == 0) || xp8;
    b8.nsclk_i  = (e8 && f8 == 2) || xn8;
    b16.psclk_i = e16 && f16 == 0;
    b16.nsclk_i = e16 && f16 == 2;
    if (b8.psclk_i && e8) begin rx8 = {rx8[30:0], b8.mosi_o}; np8++; end
    if (b16.psclk_i && e16) begin rx16 = {rx16[30:0], b16.mosi_o}; np16++; end
    @(posedge clk);
    #1;
    f8  = e8 ? (f8 + 1) % 4 : 0;
    f16 = e16 ? (f16 + 1) % 4 : 0;
    xp8 = 1'b0;
    xn8 = 1'b0;
    if (b8.fin_o) begin nfin8++; gap_on = 1'b1; hi_run = 0; end
    if (b16.fin_o) nfin16++;
    if (!b8.cs_n_o && b8.listo_o) bad_listo++;
    if (gap_on) begin
      if (b8.cs_n_o) hi_run++;
      else begin last_gap = hi_run; gap_on = 1'b0; end
    end
  endtask
  task automatic hasta_listo8();
    int k = 0;
    while (!b8.listo_o && k < 600) begin ciclo(); k++; end
    if (!b8.listo_o) chk("listo_timeout", 32'(b8.listo_o), 1);
  endtask
  task automatic hasta_fin8(input int n, input string tag);
    int k = 0;
    while (nfin8 < n && k < 600) begin ciclo(); k++; end
    if (nfin8 < n) chk(tag, nfin8, n);
  endtask
  task automatic hasta_np8(input int n, input string tag);
    int k = 0;
    while (np8 < n && k < 600) begin ciclo(); k++; end
    if (np8 < n) chk(tag, np8, n);
  endtask
  task automatic send8(input logic [7:0] d);
    b8.dato_i = d;
    b8.valido_i = 1'b1;
    hasta_listo8();
    ciclo();
    b8.valido_i = 1'b0;
  endtask
  initial begin
    int k;
    b8.dato_i = '0; b8.valido_i = 0; b8.psclk_i = 0; b8.nsclk_i = 0;
    b16.dato_i = '0; b16.valido_i = 0; b16.psclk_i = 0; b16.nsclk_i = 0;
    ciclo();
    ciclo();
    chk("rst_outs8", {b8.listo_o, b8.sclk_en_o, b8.mosi_o, b8.cs_n_o, b8.ocupado_o, b8.fin_o}, 6'b000100);
    chk("rst_outs16", {b16.listo_o, b16.sclk_en_o, b16.mosi_o, b16.cs_n_o, b16.ocupado_o, b16.fin_o}, 6'b000100);
    rst = 1'b0;
    ciclo();
    chk("idle_listo", b8.listo_o, 1);
    // 1: 0xA5
    np8 = 0; nfin8 = 0; rx8 = '0;
    send8(8'hA5);
    chk("t1_start", {b8.cs_n_o, b8.mosi_o, b8.ocupado_o, b8.listo_o}, 4'b0110);
    ciclo();
    chk("t1_setup1", b8.sclk_en_o, 0);
    ciclo();
    chk("t1_setup2", b8.sclk_en_o, 1);
    hasta_fin8(1, "t1_fin_timeout");
    chk("t1_word", rx8[7:0], 8'hA5);
    chk("t1_npsclk", np8, 8);
    chk("t1_end", {b8.cs_n_o, b8.mosi_o, b8.ocupado_o}, 3'b100);
    ciclo();
    chk("t1_fin_pulse", b8.fin_o, 0);
    chk("t1_nfin", nfin8, 1);
    // 2: back-to-back 0x3C, 0xFF with valido held
    np8 = 0; nfin8 = 0; rx8 = '0; bad_listo = 0;
    b8.dato_i = 8'h3C;
    b8.valido_i = 1'b1;
    hasta_listo8();
    ciclo();
    b8.dato_i = 8'hFF;
    hasta_fin8(1, "t2_fin1_timeout");
    ciclo();
    b8.valido_i = 1'b0;
    chk("t2_second_start", {b8.cs_n_o, b8.listo_o}, 2'b00);
    chk("t2_gap", last_gap, 1);
    hasta_fin8(2, "t2_fin2_timeout");
    chk("t2_words", rx8[15:0], 16'h3CFF);
    chk("t2_npsclk", np8, 16);
    chk("t2_nfin", nfin8, 2);
    chk("t2_listo_busy", bad_listo, 0);
    // 3: valido toggling with 0x00 during 0x81
    np8 = 0; nfin8 = 0; rx8 = '0; bad_listo = 0;
    send8(8'h81);
    for (int i = 0; i < 20; i++) begin
      b8.dato_i = 8'h00;
      b8.valido_i = (i % 2 == 0);
      ciclo();
    end
    b8.valido_i = 1'b0;
    hasta_fin8(1, "t3_fin_timeout");
    chk("t3_word", rx8[7:0], 8'h81);
    chk("t3_npsclk", np8, 8);
    chk("t3_listo_busy", bad_listo, 0);
    repeat (5) ciclo();
    chk("t3_no_extra", {b8.cs_n_o, 8'(np8)}, {1'b1, 8'd8});
    send8(8'h00);
    hasta_fin8(2, "t3_fin2_timeout");
    chk("t3_zero_word", {8'(np8), rx8[7:0]}, {8'd16, 8'h00});
    // 4: reset after the 4th psclk of 0xF0
    np8 = 0; nfin8 = 0; rx8 = '0;
    send8(8'hF0);
    hasta_np8(4, "t4_np_timeout");
    chk("t4_pre_mosi", {b8.cs_n_o, b8.mosi_o}, 2'b01);
    rst = 1'b1;
    ciclo();
    chk("t4_rst_outs", {b8.cs_n_o, b8.mosi_o, b8.sclk_en_o, b8.fin_o, b8.ocupado_o, b8.listo_o}, 6'b100000);
    rst = 1'b0;
    repeat (3) ciclo();
    chk("t4_no_fin", nfin8, 0);
    np8 = 0; rx8 = '0;
    send8(8'h0F);
    hasta_fin8(1, "t4_fin_timeout");
    chk("t4_word", rx8[7:0], 8'h0F);
    chk("t4_npsclk", np8, 8);
    // 5a: both strobes at the 3rd psclk of 0x96
    np8 = 0; nfin8 = 0; rx8 = '0;
    send8(8'h96);
    hasta_np8(2, "t5_np_timeout");
    k = 0;
    while (f8 != 0 && k < 8) begin ciclo(); k++; end
    xn8 = 1'b1;
    ciclo();
    chk("t5_both_mosi", b8.mosi_o, 0);
    chk("t5_both_np", np8, 3);
    hasta_fin8(1, "t5_fin_timeout");
    chk("t5_word", rx8[7:0], 8'h96);
    chk("t5_npsclk", np8, 8);
    // 5b: strobes in IDLE, SETUP and HOLD
    xp8 = 1'b1; xn8 = 1'b1;
    ciclo();
    chk("t5_idle", {b8.cs_n_o, b8.mosi_o, b8.sclk_en_o, b8.fin_o, b8.listo_o, b8.ocupado_o}, 6'b100010);
    np8 = 0; nfin8 = 0; rx8 = '0;
    send8(8'h55);
    xp8 = 1'b1; xn8 = 1'b1;
    ciclo();
    chk("t5_setup", {b8.cs_n_o, b8.mosi_o, b8.sclk_en_o}, 3'b000);
    ciclo();
    chk("t5_setup_en", b8.sclk_en_o, 1);
    hasta_np8(8, "t5_np8_timeout");
    xp8 = 1'b1; xn8 = 1'b1;
    ciclo();
    chk("t5_hold", {b8.cs_n_o, b8.mosi_o, b8.fin_o}, 3'b010);
    ciclo();
    chk("t5_hold_end", {b8.cs_n_o, b8.mosi_o, b8.fin_o}, 3'b101);
    chk("t5_word55", {8'(np8), rx8[7:0], 8'(nfin8)}, {8'd8, 8'h55, 8'd1});
    // 6: 16-bit 0x8001
    np16 = 0; nfin16 = 0; rx16 = '0;
    b16.dato_i = 16'h8001;
    b16.valido_i = 1'b1;
    k = 0;
    while (!b16.listo_o && k < 600) begin ciclo(); k++; end
    ciclo();
    b16.valido_i = 1'b0;
    k = 0;
    while (nfin16 < 1 && k < 600) begin ciclo(); k++; end
    if (nfin16 < 1) chk("t6_fin_timeout", nfin16, 1);
    chk("t6_word", rx16[15:0], 16'h8001);
    chk("t6_npsclk", np16, 16);
    chk("t6_nfin", nfin16, 1);
    chk("t6_end", {b16.cs_n_o, b16.mosi_o}, 2'b10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
